// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register and ALU operand select: latches decoded fields, forwards
// from EX/MEM and MEM/WB, muxes the ALU operands and flags load-use hazards.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'h0
`define ALU_SUB  4'h1
`define ALU_AND  4'h2
`define ALU_OR   4'h3
`define ALU_XOR  4'h4
`define ALU_SLL  4'h5
`define ALU_SRL  4'h6
`define ALU_SRA  4'h7
`define ALU_SLT  4'h8
`define ALU_SLTU 4'h9
`define ALU_NOP  4'hF
`endif

module alu_operand_stage #(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [DATA_WIDTH-1:0] id_pc,
   input  logic [DATA_WIDTH-1:0] id_rs1_data,
   input  logic [DATA_WIDTH-1:0] id_rs2_data,
   input  logic [DATA_WIDTH-1:0] id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [3:0]            id_alu_sel,
   input  logic                  id_a_sel,
   input  logic                  id_b_sel,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  exmem_reg_write,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic [DATA_WIDTH-1:0] exmem_result,
   input  logic                  memwb_reg_write,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic [DATA_WIDTH-1:0] memwb_result,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   output logic [3:0]            alu_sel,
   output logic                  ex_valid,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [DATA_WIDTH-1:0] ex_pc,
   output logic [DATA_WIDTH-1:0] ex_store_data,
   output logic                  load_use_hazard
);

   logic [DATA_WIDTH-1:0] ex_rs1_data;
   logic [DATA_WIDTH-1:0] ex_rs2_data;
   logic [DATA_WIDTH-1:0] ex_imm;
   logic [REG_ADDR_W-1:0] ex_rs1;
   logic [REG_ADDR_W-1:0] ex_rs2;
   logic [3:0]            ex_alu_sel;
   logic                  ex_a_sel;
   logic                  ex_b_sel;
   logic [DATA_WIDTH-1:0] fwd1;
   logic [DATA_WIDTH-1:0] fwd2;
   logic                  load_bubble;

   // Reset, flush and an empty decode slot all load the same all-zero bubble;
   // flush is checked ahead of stall so it wins when both are asserted.
   assign load_bubble = !rst_n || flush || (!stall && !id_valid);

   always_ff @(posedge clk) begin
      if (load_bubble) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_imm       <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_alu_sel   <= `ALU_NOP;
         ex_a_sel     <= 1'b0;
         ex_b_sel     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
      end else if (!stall) begin
         ex_valid     <= 1'b1;
         ex_pc        <= id_pc;
         ex_rs1_data  <= id_rs1_data;
         ex_rs2_data  <= id_rs2_data;
         ex_imm       <= id_imm;
         ex_rs1       <= id_rs1;
         ex_rs2       <= id_rs2;
         ex_rd        <= id_rd;
         ex_alu_sel   <= id_alu_sel;
         ex_a_sel     <= id_a_sel;
         ex_b_sel     <= id_b_sel;
         ex_reg_write <= id_reg_write;
         ex_mem_read  <= id_mem_read;
         ex_mem_write <= id_mem_write;
      end
   end

   // EX/MEM is the younger result, so it takes priority; x0 is never forwarded.
   always_comb begin
      fwd1 = ex_rs1_data;
      if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_rs1)
         fwd1 = exmem_result;
      else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_rs1)
         fwd1 = memwb_result;

      fwd2 = ex_rs2_data;
      if (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_rs2)
         fwd2 = exmem_result;
      else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_rs2)
         fwd2 = memwb_result;
   end

   assign alu_a         = ex_a_sel ? ex_pc : fwd1;
   assign alu_b         = ex_b_sel ? ex_imm : fwd2;
   assign alu_sel       = ex_alu_sel;
   assign ex_store_data = fwd2;

   // Both sources are checked even when a_sel/b_sel make one unused.
   assign load_use_hazard = ex_valid && ex_mem_read && (ex_rd != '0) &&
                            ((ex_rd == id_rs1) || (ex_rd == id_rs2)) && id_valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage: reset, pass-through, forwarding,
// x0 guard, load-use hazard, stall and flush.
module tb_alu_operand_stage;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_NOP = 4'hF;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_alu_sel;
   logic        id_a_sel, id_b_sel, id_reg_write, id_mem_read, id_mem_write;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
   logic [3:0]  alu_sel;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
   logic [4:0]  ex_rd;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_sel(id_alu_sel),
      .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .ex_valid(ex_valid),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
      .load_use_hazard(load_use_hazard)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow a further settle delay.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [3:0] op, input logic as, input logic bs,
                         input logic rw, input logic mr, input logic mw);
      id_valid = v; id_pc = pc; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
      id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_alu_sel = op; id_a_sel = as; id_b_sel = bs;
      id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
   endtask

   task automatic set_bus(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                          input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
      exmem_reg_write = ew; exmem_rd = erd; exmem_result = eres;
      memwb_reg_write = mw; memwb_rd = mrd; memwb_result = mres;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      // Reset must win over a valid instruction sitting in decode.
      set_id(1, 32'h40, 32'h55, 32'h66, 32'h77, 5'd1, 5'd2, 5'd3, OP_ADD, 0, 1, 1, 1, 0);
      set_bus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      tick(); tick();
      id_valid = 1'b0;
      #1;
      chk("rst_valid",  32'(ex_valid), 32'd0);
      chk("rst_sel",    32'(alu_sel), 32'(OP_NOP));
      chk("rst_a",      alu_a, 32'h0);
      chk("rst_b",      alu_b, 32'h0);
      chk("rst_pc",     ex_pc, 32'h0);
      chk("rst_hazard", 32'(load_use_hazard), 32'd0);

      rst_n = 1'b1;
      set_id(1, 32'h100, 32'd5, 32'd9, 32'd7, 5'd1, 5'd2, 5'd6, OP_ADD, 0, 1, 1, 0, 0);
      tick();
      id_valid = 1'b0;
      #1;
      chk("pt_a",     alu_a, 32'd5);
      chk("pt_b",     alu_b, 32'd7);
      chk("pt_sel",   32'(alu_sel), 32'(OP_ADD));
      chk("pt_valid", 32'(ex_valid), 32'd1);
      chk("pt_rd",    32'(ex_rd), 32'd6);
      chk("pt_pc",    ex_pc, 32'h100);
      chk("pt_store", ex_store_data, 32'd9);
      chk("pt_rw",    32'(ex_reg_write), 32'd1);

      set_id(1, 32'h104, 32'd5, 32'd9, 32'd7, 5'd1, 5'd2, 5'd6, OP_SUB, 1, 0, 1, 0, 0);
      tick(); #1;
      chk("pc_sel_a", alu_a, 32'h104);
      chk("rs2_sel_b", alu_b, 32'd9);
      chk("sub_sel",  32'(alu_sel), 32'(OP_SUB));

      // Forwarding priority on rs1, then MEM/WB forwarding on rs2.
      set_id(1, 32'h108, 32'h33, 32'h55, 32'h0, 5'd3, 5'd5, 5'd8, OP_XOR, 0, 0, 1, 0, 0);
      tick();
      set_bus(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
      #1;
      chk("fwd_exmem_pri", alu_a, 32'h11);
      chk("fwd_b_nomatch", alu_b, 32'h55);
      exmem_reg_write = 1'b0; #1;
      chk("fwd_memwb", alu_a, 32'h22);
      memwb_reg_write = 1'b0; #1;
      chk("fwd_none", alu_a, 32'h33);
      set_bus(0, 5'd3, 32'h11, 1, 5'd5, 32'h22); #1;
      chk("fwd2_memwb_b",  alu_b, 32'h22);
      chk("fwd2_memwb_st", ex_store_data, 32'h22);

      // x0 is never forwarded.
      set_id(1, 32'h10C, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd9, OP_AND, 0, 0, 1, 0, 0);
      set_bus(1, 5'd0, 32'hFF, 1, 5'd0, 32'hEE);
      tick(); #1;
      chk("x0_b",     alu_b, 32'h0);
      chk("x0_store", ex_store_data, 32'h0);
      chk("x0_a",     alu_a, 32'h0);

      // Store: ex_store_data forwards rs2 even when b selects the immediate.
      set_id(1, 32'h110, 32'h1, 32'h70, 32'h1234, 5'd1, 5'd7, 5'd0, OP_ADD, 0, 1, 0, 0, 1);
      set_bus(1, 5'd7, 32'hAB, 0, 5'd0, 32'h0);
      tick(); #1;
      chk("st_b_imm", alu_b, 32'h1234);
      chk("st_data",  ex_store_data, 32'hAB);
      chk("st_mw",    32'(ex_mem_write), 32'd1);

      // Load-use hazard.
      set_bus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      set_id(1, 32'h114, 32'h1000, 32'h0, 32'h8, 5'd1, 5'd0, 5'd4, OP_ADD, 0, 1, 1, 1, 0);
      tick();
      set_id(1, 32'h118, 32'h0, 32'h0, 32'h0, 5'd9, 5'd4, 5'd10, OP_ADD, 0, 0, 1, 0, 0);
      #1;
      chk("lu_hazard_rs2", 32'(load_use_hazard), 32'd1);
      id_valid = 1'b0; #1;
      chk("lu_novalid", 32'(load_use_hazard), 32'd0);
      id_valid = 1'b1; id_rs2 = 5'd8; #1;
      chk("lu_nomatch", 32'(load_use_hazard), 32'd0);
      id_rs1 = 5'd4; #1;
      chk("lu_hazard_rs1", 32'(load_use_hazard), 32'd1);
      stall = 1'b1; flush = 1'b1;
      tick();
      stall = 1'b0; flush = 1'b0;
      #1;
      chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
      chk("lu_bubble_mr",    32'(ex_mem_read), 32'd0);
      chk("lu_bubble_sel",   32'(alu_sel), 32'(OP_NOP));
      chk("lu_bubble_rd",    32'(ex_rd), 32'd0);
      chk("lu_clear",        32'(load_use_hazard), 32'd0);

      // Stall holds EX for three cycles while decode changes.
      set_id(1, 32'h200, 32'hA, 32'hB, 32'h0, 5'd11, 5'd12, 5'd10, OP_OR, 0, 0, 1, 0, 0);
      tick();
      stall = 1'b1;
      set_id(1, 32'h300, 32'hFFFF, 32'hEEEE, 32'h5, 5'd13, 5'd14, 5'd13, OP_AND, 1, 1, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk("stall_a",   alu_a, 32'hA);
         chk("stall_pc",  ex_pc, 32'h200);
         chk("stall_rd",  32'(ex_rd), 32'd10);
         chk("stall_sel", 32'(alu_sel), 32'(OP_OR));
      end
      set_bus(1, 5'd11, 32'h77, 0, 5'd0, 32'h0); #1;
      chk("stall_fwd_a", alu_a, 32'h77);
      set_bus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0; #1;
      chk("sf_valid", 32'(ex_valid), 32'd0);
      chk("sf_sel",   32'(alu_sel), 32'(OP_NOP));
      chk("sf_pc",    ex_pc, 32'h0);
      stall = 1'b0;
      tick(); #1;
      chk("release_pc", ex_pc, 32'h300);
      chk("release_a",  alu_a, 32'h300);
      chk("release_mr", 32'(ex_mem_read), 32'd1);

      id_valid = 1'b0;
      tick(); #1;
      chk("idle_valid", 32'(ex_valid), 32'd0);
      chk("idle_rw",    32'(ex_reg_write), 32'd0);
      chk("idle_a",     alu_a, 32'h0);
      chk("idle_sel",   32'(alu_sel), 32'(OP_NOP));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the ALU.
- Latches decoded instruction fields and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Muxes rs1/PC and rs2/imm onto the ALU a/b operands and drives alu_sel.
- Detects load-use hazards and requests a decode stall.

Parameters:
- DATA_WIDTH, `DATA_WIDTH, operand/result width (32 for RV32I).
- REG_ADDR_W, 5, register-index width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hold EX register contents
- flush  in  1  replace next EX contents with bubble
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  DATA_WIDTH  instruction PC
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices
- id_alu_sel  in  4  ALU opcode (`ALU_* encodings)
- id_a_sel  in  1  0 = rs1, 1 = PC
- id_b_sel  in  1  0 = rs2, 1 = imm
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- exmem_reg_write  in  1  EX/MEM writes rd
- exmem_rd  in  REG_ADDR_W  EX/MEM destination index
- exmem_result  in  DATA_WIDTH  EX/MEM result
- memwb_reg_write  in  1  MEM/WB writes rd
- memwb_rd  in  REG_ADDR_W  MEM/WB destination index
- memwb_result  in  DATA_WIDTH  MEM/WB result
- alu_a, alu_b  out  DATA_WIDTH  ALU operands
- alu_sel  out  4  ALU opcode
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control
- ex_rd  out  REG_ADDR_W  registered destination
- ex_pc  out  DATA_WIDTH  registered PC
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores
- load_use_hazard  out  1  decode must stall one cycle

Behaviour:
- Reset (rst_n=0 at posedge): every EX register is cleared to 0 and alu_sel = `ALU_NOP. alu_a/alu_b then read 0 unless forwarding matches; forwarding never matches, since regs 0 and x0 are excluded.
- Register update priority on each posedge: reset > flush > stall > load.
  - Flush: load a bubble (valid, reg_write, mem_read, mem_write = 0; alu_sel = `ALU_NOP; rd = 0). Other fields are don't-care but are driven to 0.
  - Stall (no flush): hold all registers.
  - Otherwise: capture all id_* fields.
  - If id_valid=0, a bubble is captured.
- Latency: one cycle from id_* inputs to alu_a/alu_b/alu_sel.
- Forwarding is combinational on the registered ex_rs1/ex_rs2 against the current exmem_*/memwb_* buses:
  - fwd1 = exmem_result if exmem_reg_write and exmem_rd != 0 and exmem_rd == ex_rs1;
  - else memwb_result under the same condition on the MEM/WB bus;
  - else registered rs1 data.
  - fwd2 uses the same rule on ex_rs2.
  - EX/MEM has priority when both buses match.
- Operand muxes:
  - alu_a = ex_a_sel ? ex_pc : fwd1
  - alu_b = ex_b_sel ? ex_imm : fwd2
  - ex_store_data = fwd2 always, independent of b_sel.
- load_use_hazard (combinational) = ex_valid & ex_mem_read & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2) & id_valid.
  - The hazard checks both sources regardless of id_a_sel/id_b_sel; this is deliberately conservative.
  - The pipeline controller responds by asserting stall upstream and flush here for one cycle, which inserts a bubble.
  - Next cycle ex_mem_read=0, so the hazard deasserts. The load result then arrives via MEM/WB forwarding.
- Simultaneous flush+stall: flush wins.
- Stall held multiple cycles: outputs stay stable. Forwarded values may change as the exmem/memwb buses change; this is intended.
- Writes to x0 are never forwarded.

Test Plan:
- Reset: rst_n=0 for 2 cycles → ex_valid=0, alu_sel=`ALU_NOP, alu_a=alu_b=0, load_use_hazard=0.
- Pass-through: id_rs1_data=5, id_imm=7, id_b_sel=1, id_alu_sel=`ALU_ADD, id_valid=1 → next cycle alu_a=5, alu_b=7, alu_sel=`ALU_ADD, ex_valid=1.
- Forward priority: ex_rs1=3; exmem(rd=3, we=1, 0x11) and memwb(rd=3, we=1, 0x22) both active → alu_a=0x11. Drop exmem_reg_write → alu_a=0x22.
- x0 guard: ex_rs2=0, exmem(rd=0, we=1, 0xFF), id_rs2_data=0 → alu_b=0, ex_store_data=0.
- Load-use: EX holds lw with rd=4; id_rs2=4, id_valid=1 → load_use_hazard=1. Apply flush → next cycle ex_valid=0, hazard=0.
- Stall/flush: stall=1 for 3 cycles with changing id_* → EX outputs are unchanged. stall=1 and flush=1 together → bubble captured, ex_valid=0.
